imm_gen: RTL and testbench
==========================

Name: imm_gen

Overview:
- Registered RV32I immediate generator in the decode stage.
- Takes a 32-bit instruction word and classifies it by opcode into a format: R, I, S, B, U or J.
- Outputs the sign-extended 32-bit immediate, the format code and an illegal-opcode flag.
- One-cycle latency, qualified by a valid strobe.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk        input   1    rising-edge clock
- rst        input   1    synchronous, active-high reset
- instr_valid input  1    instr_in is valid this cycle
- instr_in   input   32   raw instruction word
- imm_valid  output  1    imm_out/imm_fmt/illegal are valid
- imm_out    output  32   immediate, sign-extended to 32 bits
- imm_fmt    output  3    format code (R=0, I=1, S=2, B=3, U=4, J=5, NONE=7)
- illegal    output  1    opcode is not in the supported RV32I set

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset: all outputs are 0 in the cycle after rst is sampled high (imm_valid=0, imm_out=0, imm_fmt=0, illegal=0). rst has priority over instr_valid.
- Latency: exactly 1 cycle. When instr_valid=1 at edge N, outputs reflect that instruction after edge N.
- When instr_valid=0: imm_valid goes to 0; imm_out, imm_fmt and illegal hold their last values.
- Back-to-back valid instructions produce one result per cycle, with no bubbles.
- Opcode is instr_in[6:0]; the decode is combinational and the result is registered.
- I-type: opcodes LOAD 0000011, OP-IMM 0010011, JALR 1100111, FENCE 0001111, SYSTEM 1110011.
  - imm = sign-extended instr[31:20].
- OP-IMM shifts (funct3 001 or 101): imm = zero-extended instr[24:20]. Bits [31:25] are ignored; SRAI's funct7 does not leak into the immediate.
- S-type: STORE 0100011.
  - imm = sext({instr[31:25], instr[11:7]}).
- B-type: BRANCH 1100011.
  - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Bit 0 is always 0.
- U-type: LUI 0110111, AUIPC 0010111.
  - imm = {instr[31:12], 12'h000}.
  - No sign extension is needed.
- J-type: JAL 1101111.
  - imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Bit 0 is always 0.
- R-type: OP 0110011. imm = 0, fmt = R, illegal = 0.
- Any other opcode: imm = 0, fmt = NONE, illegal = 1, imm_valid still 1.
- Only the opcode, and funct3 for OP-IMM, affect decode. No funct7 legality checking.
- instr[1:0] != 2'b11 is treated as illegal, because no such opcode is in the table.
- Boundary cases:
  - Most-negative values: I gives 0xFFFFF800, B gives 0xFFFFF000, J gives 0xFFF00000.
  - All-ones fields must sign-extend correctly.
  - An instruction word of 0x00000000 is illegal.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode localparams: OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_FENCE, OPC_SYSTEM;
  - format codes FMT_R..FMT_J, FMT_NONE;
  - funct3 constants F3_SLL=001, F3_SRx=101.
- One combinational sub-module, imm_decode, maps instr to {imm, fmt, illegal}. The imm_gen top adds the valid/reset output register.

Test Plan:
- rst=1 for 2 cycles with instr_valid=1 -> all outputs 0. After release, 0x00510093 (ADDI x1,x2,5) -> next cycle imm_valid=1, imm_out=0x00000005, fmt=I, illegal=0.
- STORE 0x00112423 (SW x1,8(x2)) -> imm 0x00000008, fmt S. BRANCH 0xFE208E63 -> imm 0xFFFFF7FC (-2052), fmt B. BRANCH 0xFE208EE3 -> imm 0xFFFFFFFC (-4).
- LUI 0x123450B7 -> imm 0x12345000, fmt U. JAL 0x001000EF -> imm 0x00000800. JAL 0x010000EF -> imm 0x00000010, fmt J.
- Sign extremes:
  - 0x80000013 (ADDI) -> 0xFFFFF800.
  - 0x80000063 (BRANCH) -> 0xFFFFF000.
  - 0x8000006F (JAL) -> 0xFFF00000.
  - 0x40F0D093 (SRAI x1,x1,15) -> 0x0000000F.
- R-type 0x002081B3 -> imm 0, fmt R, illegal 0. Word 0x00000000 -> imm 0, fmt NONE, illegal 1. Opcode 0x7F -> illegal 1.
- Back-to-back valid stream of 5 instructions -> 5 consecutive correct results. Drop instr_valid -> imm_valid=0 and other outputs hold. Assert rst in the middle of the stream -> outputs cleared on the next edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcode, format and funct3 constants
package rv32i_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRx = 3'b101;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode classification and immediate extraction
module imm_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [2:0]  fmt,
  output logic        illegal
);
  logic [2:0] f3;
  assign f3 = instr[14:12];
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        fmt = FMT_I;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        // shift amounts are unsigned and must not carry SRAI's funct7
        imm = (f3 == F3_SLL || f3 == F3_SRx) ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = {instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: registered RV32I immediate generator with valid qualification
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr_in,
  output logic            imm_valid,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);
  logic [31:0] dec_imm;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  logic        imm_valid_q, imm_valid_d;
  logic [31:0] imm_out_q, imm_out_d;
  logic [2:0]  imm_fmt_q, imm_fmt_d;
  logic        illegal_q, illegal_d;
  imm_decode u_dec (
    .instr   (instr_in),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );
  always_comb begin
    imm_valid_d = instr_valid;
    imm_out_d   = instr_valid ? dec_imm : imm_out_q;
    imm_fmt_d   = instr_valid ? dec_fmt : imm_fmt_q;
    illegal_d   = instr_valid ? dec_ill : illegal_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_valid_q <= 1'b0;
      imm_out_q   <= '0;
      imm_fmt_q   <= FMT_R;
      illegal_q   <= 1'b0;
    end else begin
      imm_valid_q <= imm_valid_d;
      imm_out_q   <= imm_out_d;
      imm_fmt_q   <= imm_fmt_d;
      illegal_q   <= illegal_d;
    end
  end
  assign imm_valid = imm_valid_q;
  assign imm_out   = imm_out_q;
  assign imm_fmt   = imm_fmt_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed self-checking bench for imm_gen
module tb_imm_gen;
  import rv32i_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        imm_valid;
  logic [31:0] imm_out;
  logic [2:0]  imm_fmt;
  logic        illegal;
  int n_chk = 0;
  int n_fail = 0;

  imm_gen #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_in    (instr_in),
    .imm_valid   (imm_valid),
    .imm_out     (imm_out),
    .imm_fmt     (imm_fmt),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] imm, input logic [2:0] f, input logic ill);
    chk({tag, ".valid"}, {31'd0, imm_valid}, {31'd0, v});
    chk({tag, ".imm"}, imm_out, imm);
    chk({tag, ".fmt"}, {29'd0, imm_fmt}, {29'd0, f});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill});
  endtask

  task automatic step(input logic [31:0] ins);
    instr_valid = 1'b1;
    instr_in = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] f, input logic ill);
    step(ins);
    chk_out(tag, 1'b1, imm, f, ill);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b1;
    instr_in = 32'h00510093;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, FMT_R, 1'b0);
    rst = 1'b0;
    vec("addi",      32'h00510093, 32'h00000005, FMT_I, 1'b0);
    vec("sw",        32'h00112423, 32'h00000008, FMT_S, 1'b0);
    vec("beq_m2052", 32'hFE208E63, 32'hFFFFF7FC, FMT_B, 1'b0);
    vec("beq_m4",    32'hFE208EE3, 32'hFFFFFFFC, FMT_B, 1'b0);
    vec("lui",       32'h123450B7, 32'h12345000, FMT_U, 1'b0);
    vec("auipc",     32'hFFFFF097, 32'hFFFFF000, FMT_U, 1'b0);
    vec("jal_800",   32'h001000EF, 32'h00000800, FMT_J, 1'b0);
    vec("jal_10",    32'h010000EF, 32'h00000010, FMT_J, 1'b0);
    vec("addi_min",  32'h80000013, 32'hFFFFF800, FMT_I, 1'b0);
    vec("addi_m1",   32'hFFF00013, 32'hFFFFFFFF, FMT_I, 1'b0);
    vec("lw_m1",     32'hFFF02083, 32'hFFFFFFFF, FMT_I, 1'b0);
    vec("br_min",    32'h80000063, 32'hFFFFF000, FMT_B, 1'b0);
    vec("jal_min",   32'h8000006F, 32'hFFF00000, FMT_J, 1'b0);
    vec("jal_m2",    32'hFFFFF0EF, 32'hFFFFFFFE, FMT_J, 1'b0);
    vec("sw_m1",     32'hFE112FA3, 32'hFFFFFFFF, FMT_S, 1'b0);
    vec("srai",      32'h40F0D093, 32'h0000000F, FMT_I, 1'b0);
    vec("slli",      32'hFFF09093, 32'h0000001F, FMT_I, 1'b0);
    vec("jalr",      32'hFFC100E7, 32'hFFFFFFFC, FMT_I, 1'b0);
    vec("r_add",     32'h002081B3, 32'h00000000, FMT_R, 1'b0);
    vec("zero",      32'h00000000, 32'h00000000, FMT_NONE, 1'b1);
    vec("opc7f",     32'h0000007F, 32'h00000000, FMT_NONE, 1'b1);
    vec("low_bits",  32'h00510090, 32'h00000000, FMT_NONE, 1'b1);
    vec("s0",        32'h00112423, 32'h00000008, FMT_S, 1'b0);
    vec("s1",        32'h123450B7, 32'h12345000, FMT_U, 1'b0);
    vec("s2",        32'h80000063, 32'hFFFFF000, FMT_B, 1'b0);
    vec("s3",        32'h002081B3, 32'h00000000, FMT_R, 1'b0);
    vec("s4",        32'h010000EF, 32'h00000010, FMT_J, 1'b0);
    instr_valid = 1'b0;
    instr_in = 32'h80000013;
    @(posedge clk);
    #1;
    chk_out("hold1", 1'b0, 32'h00000010, FMT_J, 1'b0);
    @(posedge clk);
    #1;
    chk_out("hold2", 1'b0, 32'h00000010, FMT_J, 1'b0);
    vec("m0", 32'h80000013, 32'hFFFFF800, FMT_I, 1'b0);
    vec("m1", 32'h0000007F, 32'h00000000, FMT_NONE, 1'b1);
    rst = 1'b1;
    step(32'hFE208E63);
    chk_out("mid_rst", 1'b0, 32'h0, FMT_R, 1'b0);
    rst = 1'b0;
    vec("post_rst", 32'hFE208E63, 32'hFFFFF7FC, FMT_B, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
